// File: rtl/cpu4_program_loader.sv
// Instruction-memory loader: frames {A,len_m1} header, N words, 8-bit checksum into the CPU's imem.
// Latency: in_ready one cycle after start; imem write one cycle after each data beat; release one cycle after checksum.
// Backpressure: in_ready is a pure state decode; in_valid gaps stall the FSM with no state change.
module cpu4_program_loader #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic                  i_in_valid,
    output logic                  o_in_ready,
    input  logic [DATA_WIDTH-1:0] i_in_data,
    output logic                  o_imem_we,
    output logic [ADDR_WIDTH-1:0] o_imem_addr,
    output logic [DATA_WIDTH-1:0] o_imem_wdata,
    output logic                  o_cpu_reset,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_DATA,
        S_CSUM,
        S_RUN
    } state_t;

    localparam logic [3:0] HDR_MAGIC = 4'hA;

    state_t                r_state;
    state_t                w_next;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic [ADDR_WIDTH-1:0] r_len_m1;
    logic [DATA_WIDTH-1:0] r_sum;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_done;
    logic                  r_error;

    logic w_busy;
    logic w_beat;
    logic w_hdr_ok;
    logic w_last;
    logic w_sum_ok;
    logic w_start_ok;

    assign w_busy     = (r_state == S_HDR) || (r_state == S_DATA) || (r_state == S_CSUM);
    assign w_beat     = i_in_valid && w_busy;
    assign w_hdr_ok   = (i_in_data[DATA_WIDTH-1 -: 4] == HDR_MAGIC);
    assign w_last     = (r_cnt == r_len_m1);
    assign w_sum_ok   = (i_in_data == r_sum);
    // start only opens a session from a quiescent state; mid-load it is dropped
    assign w_start_ok = i_start && ((r_state == S_IDLE) || (r_state == S_RUN));

    assign o_in_ready   = w_busy;
    assign o_busy       = w_busy;
    assign o_cpu_reset  = (r_state != S_RUN);
    assign o_imem_we    = r_we;
    assign o_imem_addr  = r_addr;
    assign o_imem_wdata = r_wdata;
    assign o_done       = r_done;
    assign o_error      = r_error;

    // State register; reset wins over start and any handshake
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode driven by accepted beats and start
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_start_ok) w_next = S_HDR;
            S_HDR:  if (w_beat) w_next = w_hdr_ok ? S_DATA : S_IDLE;
            S_DATA: if (w_beat && w_last) w_next = S_CSUM;
            S_CSUM: if (w_beat) w_next = w_sum_ok ? S_RUN : S_IDLE;
            S_RUN:  if (w_start_ok) w_next = S_HDR;
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath: registered write port, running checksum, word counter, status flags
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt    <= '0;
            r_len_m1 <= '0;
            r_sum    <= '0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_done   <= 1'b0;
            r_error  <= 1'b0;
        end else begin
            r_we   <= 1'b0;
            r_done <= 1'b0;
            if (w_start_ok) begin
                r_error <= 1'b0;
            end
            if (w_beat) begin
                case (r_state)
                    S_HDR: begin
                        if (w_hdr_ok) begin
                            r_len_m1 <= i_in_data[ADDR_WIDTH-1:0];
                            r_cnt    <= '0;
                            r_sum    <= '0;
                        end else begin
                            r_error <= 1'b1;
                        end
                    end
                    S_DATA: begin
                        r_we    <= 1'b1;
                        r_addr  <= r_cnt;
                        r_wdata <= i_in_data;
                        r_sum   <= r_sum + i_in_data;
                        r_cnt   <= r_cnt + ADDR_WIDTH'(1);
                    end
                    S_CSUM: begin
                        if (w_sum_ok) begin
                            r_done <= 1'b1;
                        end else begin
                            r_error <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: doc/cpu4_program_loader.md
# cpu4_program_loader

Program loader that fills the 4-bit CPU's 16×8 instruction memory from a byte stream, the writer side of the instruction-memory interface the CPU reads from. It accepts a framed stream (header, N instruction words, checksum) over a valid/ready handshake and drives the memory write port. It holds the CPU in reset for the whole load and releases it only after the checksum has been verified.

## Interface
- ADDR_WIDTH, default 4: instruction memory address width (16 words).
- DATA_WIDTH, default 8: instruction word width, {opcode[7:4], operand[3:0]}.
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  pulse; begins a load session. Honoured in IDLE and RUN, ignored otherwise.
- in_valid  in  1  stream byte valid.
- in_ready  out  1  loader can accept a byte.
- in_data  in  8  stream byte.
- imem_we  out  1  instruction memory write enable.
- imem_addr  out  4  write address.
- imem_wdata  out  8  write data.
- cpu_reset  out  1  reset to CPU_4bit; high except in RUN.
- busy  out  1  high in HDR, DATA and CSUM.
- done  out  1  one-cycle pulse on a successful load.
- error  out  1  sticky framing or checksum failure; cleared by start or reset.

## Operation
- States are IDLE, HDR, DATA, CSUM and RUN.
- A beat is accepted on a rising edge with in_valid && in_ready.
- in_ready = 1 exactly in HDR, DATA and CSUM. It is decoded from state (combinational).
- IDLE, start=1 -> HDR; error <= 0; cpu_reset stays 1.
- RUN, start=1 -> HDR; cpu_reset <= 1; error <= 0.
- HDR beat: the byte must be {4'hA, len_m1}.
  - Valid header: N = len_m1 + 1 (1..16); word counter <= 0; sum <= 0; -> DATA.
  - Upper nibble != 4'hA: error <= 1 and -> IDLE. No memory writes occur.
- DATA beat:
  - imem_we <= 1, imem_addr <= counter, imem_wdata <= in_data.
  - sum <= sum + in_data, modulo 256.
  - counter increments.
  - After the Nth beat -> CSUM. The address never exceeds N-1, so no wrap occurs.
- CSUM beat:
  - in_data == sum: -> RUN, cpu_reset <= 0, done <= 1.
  - Otherwise: error <= 1, -> IDLE, cpu_reset stays 1.
- RUN: the loader is passive. cpu_reset = 0, in_ready = 0. Memory contents are untouched.
- A failed or aborted load never clears memory. Partial contents remain, but the CPU stays in reset.
- start while busy is ignored.
- in_data is ignored whenever in_ready = 0.

## Timing
Reset values (on the cycle after reset is sampled high):
- State IDLE.
- cpu_reset = 1.
- in_ready = 0, imem_we = 0, imem_addr = 0, imem_wdata = 0.
- busy = 0, done = 0, error = 0.
- Internal counter = 0 and sum = 0.

Reset priority and mid-operation reset:
- Reset overrides start and any handshake in the same cycle.
- Reset asserted mid-load returns to IDLE immediately. imem_we = 0 from the next cycle.

Write port timing:
- The write port is registered: imem_we/addr/wdata are valid in the cycle after the accepting edge.
- imem_we is high for exactly one cycle per DATA beat.

Latency:
- Start to ready: start at edge t gives in_ready = 1 in the cycle after t.
- Release: the checksum beat accepted at edge t gives cpu_reset = 0 and done = 1 in the cycle after t. done drops one cycle later.
- The last memory write always completes at least one cycle before cpu_reset falls.
- Minimum full load of N words takes N + 2 accepted beats, i.e. N + 3 cycles from start at full throughput.

Throughput and backpressure:
- in_valid gaps stall the FSM with no state change.
- One beat per cycle is sustained.

## Test plan
- Reset -> all outputs at their reset values, including cpu_reset = 1. start with no stream -> busy = 1 and in_ready = 1 the next cycle.
- start, then 0xA4, 0x13, 0x24, 0x30, 0x50, 0x40, 0xF7 -> writes to addresses 0..4 with those bytes, done pulses once, cpu_reset falls. The CPU then runs LOAD_A 3, LOAD_B 4, ADD, OUT and produces output_data = 7.
- Same stream with checksum 0xF6 -> error = 1, no done, cpu_reset stays 1, state returns to IDLE.
- Header 0x54 -> error = 1 after one beat, zero imem_we pulses.
- Header 0xAF with 16 words of 0xFF, random in_valid gaps, checksum 0xF0 -> addresses 0..15 each written once, done = 1. This exercises the 8-bit sum wrap.
- reset raised after the 2nd DATA beat -> IDLE and cpu_reset = 1 on the next cycle. A subsequent clean load succeeds. start issued in RUN -> cpu_reset rises the next cycle and a reload proceeds.
